// File: rtl/logic_unit_arbiter.sv
// Two-port arbiter/sequencer for the 16-bit combinational logic unit: grant, execute, hold response.
// Define LU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module logic_unit_arbiter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic [W-1:0] lu_a,
    output logic [W-1:0] lu_b,
    output logic [2:0]   lu_op,
    input  logic [W-1:0] lu_out,
    input  logic         lu_eq,
    input  logic         lu_gt,
    input  logic         lu_lt,
    input  logic         lu_za,
    input  logic         lu_zb,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_eq,
    output logic         rsp_gt,
    output logic         rsp_lt,
    output logic         rsp_za,
    output logic         rsp_zb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic           grant_any;
    logic           grant_id;
    logic [W-1:0]   lu_a_reg;
    logic [W-1:0]   lu_b_reg;
    logic [2:0]     lu_op_reg;
    logic           id_reg;
    logic [W-1:0]   data_reg;
    logic [4:0]     flags_reg;
`ifdef LU_ARB_RR_EN
    logic           last_id_reg;
`endif

    // Winner selection; only meaningful while grant_any is high.
    always_comb begin
        grant_any = req0_valid | req1_valid;
`ifdef LU_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            grant_id = ~last_id_reg;
        end else begin
            grant_id = req1_valid;
        end
`else
        grant_id = req1_valid & ~req0_valid;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready is a combinational accept pulse; gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rst_n && grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                end
            end
            DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_a_reg    <= '0;
            lu_b_reg    <= '0;
            lu_op_reg   <= 3'b000;
            id_reg      <= 1'b0;
            data_reg    <= '0;
            flags_reg   <= 5'b0;
`ifdef LU_ARB_RR_EN
            last_id_reg <= 1'b1;
`endif
        end else begin
            if (state_reg == IDLE && grant_any) begin
                lu_a_reg    <= grant_id ? req1_a  : req0_a;
                lu_b_reg    <= grant_id ? req1_b  : req0_b;
                lu_op_reg   <= grant_id ? req1_op : req0_op;
                id_reg      <= grant_id;
`ifdef LU_ARB_RR_EN
                last_id_reg <= grant_id;
`endif
            end
            if (state_reg == EXEC) begin
                data_reg  <= lu_out;
                flags_reg <= {lu_eq, lu_gt, lu_lt, lu_za, lu_zb};
            end
        end
    end

    assign lu_a     = lu_a_reg;
    assign lu_b     = lu_b_reg;
    assign lu_op    = lu_op_reg;
    assign rsp_id   = id_reg;
    assign rsp_data = data_reg;
    assign rsp_eq   = flags_reg[4];
    assign rsp_gt   = flags_reg[3];
    assign rsp_lt   = flags_reg[2];
    assign rsp_za   = flags_reg[1];
    assign rsp_zb   = flags_reg[0];

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table plus reset, contention and back-pressure sequences.
module tb_logic_unit_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] lu_a, lu_b, lu_out;
    logic [2:0]   lu_op;
    logic         lu_eq, lu_gt, lu_lt, lu_za, lu_zb;
    logic         rsp_valid, rsp_id;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_eq, rsp_gt, rsp_lt, rsp_za, rsp_zb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op),
        .lu_out(lu_out), .lu_eq(lu_eq), .lu_gt(lu_gt), .lu_lt(lu_lt),
        .lu_za(lu_za), .lu_zb(lu_zb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt),
        .rsp_lt(rsp_lt), .rsp_za(rsp_za), .rsp_zb(rsp_zb)
    );

    // External combinational logic unit.
    always_comb begin
        case (lu_op)
            3'b000:  lu_out = lu_a & lu_b;
            3'b001:  lu_out = lu_a | lu_b;
            3'b010:  lu_out = ~(lu_a | lu_b);
            3'b011:  lu_out = ~(lu_a & lu_b);
            3'b100:  lu_out = ~lu_a;
            3'b101:  lu_out = ~lu_b;
            3'b110:  lu_out = lu_a ^ lu_b;
            default: lu_out = ~(lu_a ^ lu_b);
        endcase
        lu_eq = (lu_a == lu_b);
        lu_gt = (lu_a > lu_b);
        lu_lt = (lu_a < lu_b);
        lu_za = (lu_a == '0);
        lu_zb = (lu_b == '0);
    end

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] exp_data;
        logic [4:0]   exp_flags;   // {eq, gt, lt, za, zb}
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt, rsp_za, rsp_zb},
              32'h0);
        check({name, "_data"}, {rsp_data, lu_a}, 32'h0);
        check({name, "_lub"}, {lu_b, 13'h0, lu_op}, 32'h0);
    endtask

    task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] op);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Called with the DUT in IDLE, inputs changing 1ns after a rising edge.
    task automatic run_vec(input int idx, input vec_t v);
        drive_req(v.id, v.a, v.b, v.op);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("accept_ready", {req1_ready, req0_ready}, v.id ? 32'h2 : 32'h1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("exec_state", {req1_ready, req0_ready, rsp_valid}, 32'h0);
        check("lu_operands", {lu_a, lu_b}, {v.a, v.b});
        check("lu_opcode", lu_op, v.op);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, v.id);
        check("rsp_data", rsp_data, v.exp_data);
        check("rsp_flags", {rsp_eq, rsp_gt, rsp_lt, rsp_za, rsp_zb}, v.exp_flags);
        $display("txn %0d: id=%0d a=%h b=%h op=%0d -> data=%h flags=%b",
                 idx, rsp_id, v.a, v.b, v.op, rsp_data, {rsp_eq, rsp_gt, rsp_lt, rsp_za, rsp_zb});
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h00FF, 16'h0F0F, 3'b000, 16'h000F, 5'b00100};
        vecs[1] = '{1'b1, 16'h0000, 16'h0000, 3'b111, 16'hFFFF, 5'b10011};
        vecs[2] = '{1'b0, 16'hA5A5, 16'h5A5A, 3'b000, 16'h0000, 5'b01000};
        vecs[3] = '{1'b1, 16'hA5A5, 16'h5A5A, 3'b001, 16'hFFFF, 5'b01000};
        vecs[4] = '{1'b0, 16'hA5A5, 16'h5A5A, 3'b010, 16'h0000, 5'b01000};
        vecs[5] = '{1'b1, 16'hA5A5, 16'h5A5A, 3'b011, 16'hFFFF, 5'b01000};
        vecs[6] = '{1'b0, 16'hA5A5, 16'h5A5A, 3'b100, 16'h5A5A, 5'b01000};
        vecs[7] = '{1'b1, 16'hA5A5, 16'h5A5A, 3'b101, 16'hA5A5, 5'b01000};
        vecs[8] = '{1'b0, 16'hA5A5, 16'h5A5A, 3'b110, 16'hFFFF, 5'b01000};
        vecs[9] = '{1'b1, 16'hA5A5, 16'h5A5A, 3'b111, 16'h0000, 5'b01000};

        // Reset state, with a request pending to show ready stays low.
        req0_valid = 1'b1;
        #12;
        check_all_zero("reset_state");
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Back-pressure: DONE holds while req1 waits.
        drive_req(1'b0, 16'h1234, 16'h00F0, 3'b000);
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_accept", {req1_ready, req0_ready}, 32'h1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive_req(1'b1, 16'h0F00, 16'h0F00, 3'b001);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold", {req1_ready, req0_ready, rsp_valid, rsp_id, rsp_data}, {3'b001, 1'b0, 16'h0030});
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_done", {rsp_valid, req1_ready}, 32'h2);
        @(negedge clk);
        check("bp_idle_grant", {rsp_valid, req1_ready}, 32'h1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_second_rsp", {rsp_valid, rsp_id, rsp_data, rsp_eq}, {2'b11, 16'h0F00, 1'b1});
        $display("txn bp: id=%0d data=%h", rsp_id, rsp_data);
        @(posedge clk); #1;

        // Contention: both requesters continuously valid.
        drive_req(1'b0, 16'h0001, 16'h0003, 3'b001);
        drive_req(1'b1, 16'h0010, 16'h0030, 3'b001);
        for (int g = 0; g < 4; g++) begin
            logic exp_id;
            bit   seen;
`ifdef LU_ARB_RR_EN
            exp_id = g[0];
`else
            exp_id = 1'b0;
`endif
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) seen = 1'b1;
            end
            check("cont_grant", {seen, req1_ready, req0_ready}, exp_id ? 32'h6 : 32'h5);
            @(negedge clk);
            @(negedge clk);
            check("cont_rsp_id", {rsp_valid, rsp_id, rsp_data}, {1'b1, exp_id, exp_id ? 16'h0030 : 16'h0003});
            $display("txn cont %0d: id=%0d data=%h", g, rsp_id, rsp_data);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of DONE, then a normal transaction.
        drive_req(1'b0, 16'hFFFF, 16'h00FF, 3'b110);
        rsp_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_done", {rsp_valid, rsp_data}, {1'b1, 16'hFF00});
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", rsp_valid, 0);
        @(posedge clk); #1;
        run_vec(99, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Sequencer and two-port arbiter for the 16-bit ALU logic unit. Two independent requesters submit operand/opcode transactions. The block grants one at a time, drives the shared logic unit from registered operands, and captures the result plus the compare/zero flags (eq, gt, lt, za, zb). It returns them to the winning requester over a valid/ready response channel. It sits between the CPU issue stage (requester 0) and the auxiliary/debug path (requester 1) and the combinational logic unit.

## Interface
- W, 16, operand/result width; must match the logic unit width.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid / req1_valid  input  1  requester n has a transaction pending.
- req0_ready / req1_ready  output  1  one-cycle accept pulse to requester n.
- req0_a, req0_b / req1_a, req1_b  input  W  operands.
- req0_op / req1_op  input  3  logic-unit opcode (000 AND … 111 XNOR).
- lu_a, lu_b  output  W  operands to the logic unit (registered).
- lu_op  output  3  opcode to the logic unit (registered).
- lu_out  input  W  logic unit result.
- lu_eq, lu_gt, lu_lt, lu_za, lu_zb  input  1  logic unit flags.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that owns the response (0/1).
- rsp_data  output  W  captured result.
- rsp_eq, rsp_gt, rsp_lt, rsp_za, rsp_zb  output  1  captured flags.

## Operation
- FSM states: IDLE, EXEC, DONE. The reset state is IDLE.
- IDLE
  - If either reqn_valid is high, arbitrate.
  - Latch the winner's a/b/op into lu_a/lu_b/lu_op and its index into the id register.
  - Pulse the winner's reqn_ready for exactly that cycle.
  - Go to EXEC.
  - If neither requester is valid, stay in IDLE.
- EXEC
  - lu_* are stable for the whole cycle.
  - At the closing edge, capture lu_out into rsp_data and the five flags into rsp_*. Go to DONE.
- DONE
  - rsp_valid=1. rsp_data/flags/id are held stable.
  - If rsp_ready=1, go to IDLE at the next edge. Otherwise stay.
- Requester rules
  - A requester must hold valid, a, b and op stable until it sees its ready pulse.
  - reqn_ready is never asserted outside IDLE.
  - Both readies are never asserted in the same cycle.
- Arbitration when both requesters are valid: round-robin (see Configuration). The register last_id records the most recent grant.
- lu_a/lu_b/lu_op keep the last transaction's values in DONE and IDLE. They change only on a grant.
- The logic unit is combinational. No arithmetic is done in this block. All widths pass through unchanged.

## Timing
- Reset values:
  - All outputs are 0: reqn_ready, rsp_valid, rsp_id, rsp_data, rsp flags, lu_a, lu_b and lu_op (=000, AND).
  - last_id=1, so requester 0 wins first.
- Latency:
  - Accept edge = cycle 0.
  - EXEC during cycle 1.
  - rsp_valid high from cycle 2.
- Throughput: with rsp_ready tied high, one transaction per 3 cycles.
- Back-pressure: DONE holds indefinitely while rsp_ready=0, and no new grant occurs.
- Simultaneous events:
  - A valid that rises in the same cycle rsp_ready completes in DONE is not accepted until the following IDLE cycle.
- Reset mid-operation:
  - rst_n low forces IDLE immediately (asynchronously) and clears all outputs. The in-flight transaction is dropped with no response.
  - The requester must resubmit.
- Requester withdrawal: a requester that drops valid before its ready pulse is simply not granted.

## Configuration
- LU_ARB_RR_EN
  - Defined: round-robin. With both valid in IDLE, grant the index != last_id, then update last_id.
  - Undefined: fixed priority. Requester 0 always wins when both are valid. last_id is not implemented and rsp_id is still produced.

## Test plan
- Reset: assert rst_n=0 mid-DONE -> all outputs 0 and state IDLE within the same cycle. After release, a single req0 completes normally.
- Single transaction: req0 with a=16'h00FF, b=16'h0F0F, op=000 -> req0_ready pulse at cycle 0. At cycle 2, rsp_valid=1, rsp_id=0, rsp_data=16'h000F, eq=0, gt=0, lt=1, za=0, zb=0.
- Flags: req1 with a=b=16'h0000, op=111 -> rsp_id=1, rsp_data=16'hFFFF, eq=1, za=1, zb=1, gt=0, lt=0.
- Contention (LU_ARB_RR_EN defined): both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id follows the same sequence.
  - Undefined: grants are 0,0,0.
- Back-pressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid stays 1, data stable, no reqn_ready pulses. Raising rsp_ready gives IDLE on the next cycle.
- Opcode sweep: a=16'hA5A5, b=16'h5A5A, op 000..111 -> rsp_data 0000, FFFF, 0000, FFFF, 5A5A, A5A5, FFFF, 0000.
